// File: rtl/commit_trace_serializer.sv
// ---------------------------------------------------------------------------
// commit_trace_serializer
//
// Collects up to NRET retired instructions per cycle from a superscalar
// commit stage and presents them one at a time to a lock-step checker.
// Valid channels of a cycle are compacted in ascending channel order into a
// circular FIFO. If a cycle arrives with no room for a full NRET group, every
// channel of that cycle is dropped. The block then enters a sticky overflow
// state and accepts nothing more until flush. Entries already queued can
// still drain.
//
// Optional feature (macro COMMIT_TRACE_SEQNUM_EN): each accepted commit is
// stamped with a 16-bit running sequence number. Reset and flush clear this
// number. Dropped commits do not advance it. Without the macro, out_seq is
// tied to zero and no sequence field is stored.
//
// Parameters:
//   NRET  - commit channels per cycle (1..4)
//   DEPTH - FIFO entries (power of two, >= 2*NRET)
//   XLEN  - pc/inst/cause width
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - per-channel commit valid, bit i = channel i
//   in_pc      - channel i pc at [i*XLEN +: XLEN]
//   in_inst    - channel i instruction, same packing
//   in_trap    - channel i raised an exception
//   in_cause   - channel i exception cause, same packing
//   in_ready   - high when at least NRET entries are free and not overflowed
//   flush      - synchronous clear of FIFO, overflow and sequence counter
//   out_valid  - an entry is presented to the checker
//   out_ready  - checker accepts the presented entry
//   out_pc/out_inst/out_cause/out_trap/out_seq - presented entry
//   overflow   - sticky, a commit was dropped
// ---------------------------------------------------------------------------
module commit_trace_serializer #(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRET-1:0]      in_valid,
    input  logic [NRET*XLEN-1:0] in_pc,
    input  logic [NRET*XLEN-1:0] in_inst,
    input  logic [NRET-1:0]      in_trap,
    input  logic [NRET*XLEN-1:0] in_cause,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_inst,
    output logic [XLEN-1:0]      out_cause,
    output logic                 out_trap,
    output logic [15:0]          out_seq,
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NRET_C  = CW'(NRET);

    typedef enum logic [1:0] {
        EMPTY,
        STREAM,
        OVF
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;

    logic [XLEN-1:0]  r_memPc    [DEPTH];
    logic [XLEN-1:0]  r_memInst  [DEPTH];
    logic [XLEN-1:0]  r_memCause [DEPTH];
    logic [DEPTH-1:0] r_memTrap;

    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_countNext;
    logic             r_overflow;

    logic             w_anyValid;
    logic             w_enq;
    logic             w_drop;
    logic             w_deq;
    logic [CW-1:0]    w_enqNum;
    logic [AW-1:0]    w_slot [NRET];

`ifdef COMMIT_TRACE_SEQNUM_EN
    logic [15:0]      r_memSeq [DEPTH];
    logic [15:0]      r_seqCnt;
    logic [15:0]      w_seqStamp [NRET];
`endif

    // Handshake qualifiers. Flush overrides both sides of the FIFO in its
    // cycle. A cycle that cannot be taken as a whole is dropped as a whole.
    assign w_anyValid = |in_valid;
    assign in_ready   = (r_state != OVF) && ((DEPTH_C - r_count) >= NRET_C);
    assign w_enq      = w_anyValid && in_ready && !flush;
    assign w_drop     = w_anyValid && !in_ready && !flush;
    assign w_deq      = out_valid && out_ready && !flush;
    assign overflow   = r_overflow;

    // Compaction: each valid channel lands at the write pointer plus the
    // number of valid channels below it. The running count also gives the
    // total number of entries enqueued this cycle.
    always_comb begin
        w_enqNum = '0;
        for (int i = 0; i < NRET; i++) begin
            w_slot[i] = r_wrPtr + AW'(w_enqNum);
`ifdef COMMIT_TRACE_SEQNUM_EN
            w_seqStamp[i] = r_seqCnt + 16'(w_enqNum);
`endif
            if (in_valid[i]) begin
                w_enqNum = w_enqNum + CW'(1);
            end
        end
    end

    // Occupancy after this cycle: enqueue and dequeue may both happen in
    // the same cycle.
    always_comb begin
        w_countNext = r_count;
        if (flush) begin
            w_countNext = '0;
        end else begin
            w_countNext = r_count + (w_enq ? w_enqNum : '0) - {{(CW-1){1'b0}}, w_deq};
        end
    end

    // Next-state logic. Overflow is sticky until flush. Otherwise the state
    // follows whether the FIFO will hold anything after this cycle.
    always_comb begin
        w_stateNext = r_state;
        if (flush) begin
            w_stateNext = EMPTY;
        end else if (w_drop || (r_state == OVF)) begin
            w_stateNext = OVF;
        end else if (w_countNext != '0) begin
            w_stateNext = STREAM;
        end else begin
            w_stateNext = EMPTY;
        end
    end

    // Control state. Reset empties the FIFO at once by clearing the
    // occupancy, so stale storage contents are never presented.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
`ifdef COMMIT_TRACE_SEQNUM_EN
            r_seqCnt   <= '0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            if (flush) begin
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_overflow <= 1'b0;
`ifdef COMMIT_TRACE_SEQNUM_EN
                r_seqCnt   <= '0;
`endif
            end else begin
                if (w_enq) begin
                    r_wrPtr <= r_wrPtr + AW'(w_enqNum);
`ifdef COMMIT_TRACE_SEQNUM_EN
                    r_seqCnt <= r_seqCnt + 16'(w_enqNum);
`endif
                end
                if (w_deq) begin
                    r_rdPtr <= r_rdPtr + AW'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Entry storage. This block needs no reset because occupancy alone
    // decides which slots are live.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            for (int i = 0; i < NRET; i++) begin
                if (in_valid[i]) begin
                    r_memPc[w_slot[i]]    <= in_pc[i*XLEN +: XLEN];
                    r_memInst[w_slot[i]]  <= in_inst[i*XLEN +: XLEN];
                    r_memCause[w_slot[i]] <= in_cause[i*XLEN +: XLEN];
                    r_memTrap[w_slot[i]]  <= in_trap[i];
`ifdef COMMIT_TRACE_SEQNUM_EN
                    r_memSeq[w_slot[i]]   <= w_seqStamp[i];
`endif
                end
            end
        end
    end

    // Output view of the FIFO head. The fields are forced to zero while
    // nothing is presented, so an asynchronous reset clears them at once.
    assign out_valid = (r_state != EMPTY) && (r_count != '0);
    assign out_pc    = out_valid ? r_memPc[r_rdPtr]    : '0;
    assign out_inst  = out_valid ? r_memInst[r_rdPtr]  : '0;
    assign out_cause = out_valid ? r_memCause[r_rdPtr] : '0;
    assign out_trap  = out_valid ? r_memTrap[r_rdPtr]  : 1'b0;
`ifdef COMMIT_TRACE_SEQNUM_EN
    assign out_seq   = out_valid ? r_memSeq[r_rdPtr]   : 16'h0;
`else
    assign out_seq   = 16'h0;
`endif

endmodule

// File: tb/tb_commit_trace_serializer.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_serializer
//
// Testbench for commit_trace_serializer with NRET=2, DEPTH=8, XLEN=32.
// A table of per-cycle vectors gives the inputs and the expected in_ready
// and overflow values. A scoreboard queue holds every commit the bench
// expects to be accepted, and the FIFO head is compared against the front
// of this queue. Hand-written sequences cover the fill/overflow/drain/flush
// path and an asynchronous reset taken while entries are queued.
// When COMMIT_TRACE_SEQNUM_EN is defined, the expected out_seq values come
// from the bench's own counter. Otherwise out_seq must be zero.
// ---------------------------------------------------------------------------
module tb_commit_trace_serializer;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam logic [31:0] INST_KEY = 32'hA5A5_0000;

`ifdef COMMIT_TRACE_SEQNUM_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic                 clock;
    logic                 reset;
    logic [NRET-1:0]      in_valid;
    logic [NRET*XLEN-1:0] in_pc;
    logic [NRET*XLEN-1:0] in_inst;
    logic [NRET-1:0]      in_trap;
    logic [NRET*XLEN-1:0] in_cause;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_inst;
    logic [XLEN-1:0]      out_cause;
    logic                 out_trap;
    logic [15:0]          out_seq;
    logic                 overflow;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cause;
        logic        trap;
        logic [15:0] seq;
    } entry_t;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  trap;
        logic [31:0] cause;
        logic        outReady;
        logic        expReady;
        logic        expOvf;
    } vec_t;

    entry_t      sb[$];
    logic [15:0] mSeq;
    int          checks;
    int          failures;
    vec_t        vecs[15];

    commit_trace_serializer #(
        .NRET (NRET),
        .DEPTH(DEPTH),
        .XLEN (XLEN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .in_trap  (in_trap),
        .in_cause (in_cause),
        .in_ready (in_ready),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_inst (out_inst),
        .out_cause(out_cause),
        .out_trap (out_trap),
        .out_seq  (out_seq),
        .overflow (overflow)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison: counts the check and reports any difference.
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs. Channel 1 carries cause+1 so that the two
    // channels can be told apart.
    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pc0,
                                 input logic [31:0] pc1, input logic [1:0] trap,
                                 input logic [31:0] cause, input logic outReady,
                                 input logic flushIn);
        in_valid  = valid;
        in_pc     = {pc1, pc0};
        in_inst   = {pc1 ^ INST_KEY, pc0 ^ INST_KEY};
        in_trap   = trap;
        in_cause  = {cause + 32'h1, cause};
        out_ready = outReady;
        flush     = flushIn;
    endtask

    // Compare the DUT outputs against the bench expectations and the
    // scoreboard head.
    task automatic checkOutput(input logic expReady, input logic expOvf);
        entry_t e;
        compare("in_ready", {31'h0, in_ready}, {31'h0, expReady});
        compare("overflow", {31'h0, overflow}, {31'h0, expOvf});
        compare("out_valid", {31'h0, out_valid}, {31'h0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            e = sb[0];
            compare("out_pc", out_pc, e.pc);
            compare("out_inst", out_inst, e.inst);
            compare("out_cause", out_cause, e.cause);
            compare("out_trap", {31'h0, out_trap}, {31'h0, e.trap});
            compare("out_seq", {16'h0, out_seq}, {16'h0, (SEQ_EN ? e.seq : 16'h0)});
        end
    endtask

    // One clock cycle. Outputs are checked at the falling edge. The
    // scoreboard is then updated from the driven inputs. If a commit is
    // expected to be accepted, the entries are pushed. A pop happens
    // whenever the checker takes the head.
    task automatic tick(input logic expReady, input logic expOvf);
        entry_t e;
        @(negedge clock);
        checkOutput(expReady, expOvf);
        if (flush) begin
            sb.delete();
            mSeq = 16'h0;
        end else begin
            if (out_ready && sb.size() != 0) begin
                void'(sb.pop_front());
            end
            if (expReady && in_valid != 2'b00) begin
                for (int ch = 0; ch < NRET; ch++) begin
                    if (in_valid[ch]) begin
                        e.pc    = in_pc[ch*XLEN +: XLEN];
                        e.inst  = in_pc[ch*XLEN +: XLEN] ^ INST_KEY;
                        e.cause = in_cause[ch*XLEN +: XLEN];
                        e.trap  = in_trap[ch];
                        e.seq   = mSeq;
                        mSeq    = mSeq + 16'h1;
                        sb.push_back(e);
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mSeq     = 16'h0;
        reset    = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);

        // Vector table: {valid, pc0, pc1, trap, cause, outReady, expReady, expOvf}
        vecs[0]  = '{2'b11, 32'h100, 32'h104, 2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, 32'h1F0, 32'h200, 2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{2'b01, 32'h300, 32'h3F0, 2'b01, 32'h2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'b11, 32'h400, 32'h404, 2'b10, 32'h8, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 32'h408, 32'h40C, 2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{2'b00, 32'h0,   32'h0,   2'b00, 32'h0, 1'b1, 1'b1, 1'b0};

        // Values held while reset is asserted.
        #12;
        compare("rst_out_valid", {31'h0, out_valid}, 32'h0);
        compare("rst_out_pc", out_pc, 32'h0);
        compare("rst_out_trap", {31'h0, out_trap}, 32'h0);
        compare("rst_out_seq", {16'h0, out_seq}, 32'h0);
        compare("rst_overflow", {31'h0, overflow}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        $display("[TB] table vectors");
        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].valid, vecs[v].pc0, vecs[v].pc1, vecs[v].trap,
                          vecs[v].cause, vecs[v].outReady, 1'b0);
            tick(vecs[v].expReady, vecs[v].expOvf);
        end

        $display("[TB] fill, overflow, drain, flush");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 32'(32'h500 + k * 8), 32'(32'h504 + k * 8), 2'b00, 32'h0, 1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
        applyStimulus(2'b11, 32'h5F0, 32'h5F4, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b11, 32'(32'h6F0 + k * 8), 32'(32'h6F4 + k * 8), 2'b00, 32'h0, 1'b1, 1'b0);
            tick(1'b0, 1'b1);
        end
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 1'b1);
        applyStimulus(2'b11, 32'h700, 32'h704, 2'b00, 32'h0, 1'b1, 1'b1);
        tick(1'b0, 1'b1);
        applyStimulus(2'b11, 32'h600, 32'h604, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        $display("[TB] asynchronous reset with entries queued");
        applyStimulus(2'b11, 32'h800, 32'h804, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        applyStimulus(2'b11, 32'h808, 32'h80C, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        applyStimulus(2'b01, 32'h810, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
        compare("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        compare("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
        compare("async_rst_out_pc", out_pc, 32'h0);
        sb.delete();
        mSeq = 16'h0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick(1'b1, 1'b0);
        applyStimulus(2'b01, 32'h900, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commit_trace_serializer.md
COMMIT_TRACE_SERIALIZER -- requirements
Module: commit_trace_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, meaning commit channels per cycle (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, DEPTH >= 2*NRET).
REQ-003 SHALL have parameter XLEN, default 32, meaning pc/inst/cause width.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-006 SHALL have port in_valid  input  NRET  per-channel commit valid; bit i = channel i.
REQ-007 SHALL have port in_pc  input  NRET*XLEN  channel i pc at bits [i*XLEN +: XLEN].
REQ-008 SHALL have port in_inst  input  NRET*XLEN  channel i instruction, same packing.
REQ-009 SHALL have port in_trap  input  NRET  channel i commit raised an exception.
REQ-010 SHALL have port in_cause  input  NRET*XLEN  channel i exception cause, same packing.
REQ-011 SHALL have port in_ready  output  1  high when free entries >= NRET.
REQ-012 SHALL have port flush  input  1  synchronous clear of FIFO and overflow state.
REQ-013 SHALL have port out_valid  output  1  serialized entry available to the checker.
REQ-014 SHALL have port out_ready  input  1  checker accepts the entry.
REQ-015 SHALL have ports out_pc, out_inst, out_cause  output  XLEN each; out_trap  output  1.
REQ-016 SHALL have port out_seq  output  16  commit sequence number of the presented entry.
REQ-017 SHALL have port overflow  output  1  sticky: a commit was dropped.

Function
REQ-018 SHALL enqueue, each cycle, all channels with in_valid set, compacted in ascending channel order, when in_ready is high and state is not OVF.
REQ-019 SHALL drop all channels of a cycle (none partially) and enter OVF when any in_valid bit is set while in_ready is low.
REQ-020 SHALL dequeue exactly one entry per cycle when out_valid && out_ready.
REQ-021 SHALL handle simultaneous enqueue and dequeue in the same cycle; occupancy = old + enqueued - dequeued.
REQ-022 SHALL keep occupancy in a $clog2(DEPTH)+1-bit counter; read/write pointers wrap modulo DEPTH.
REQ-023 SHALL present an entry enqueued in cycle N on out_* no earlier than cycle N+1 (no combinational in->out path).
REQ-024 SHALL hold out_* stable while out_valid && !out_ready.
REQ-025 SHALL drive out_valid = (occupancy != 0) in states STREAM and OVF.
REQ-026 SHALL implement states EMPTY (occupancy 0), STREAM (occupancy > 0), OVF (overflow seen).
REQ-027 SHALL transition EMPTY->STREAM on enqueue; STREAM->EMPTY when last entry dequeued with no enqueue; any->OVF on a drop; OVF->EMPTY only on flush.
REQ-028 SHALL, in OVF, still drain remaining entries but accept no new ones; in_ready = 0.
REQ-029 SHALL, on flush, clear occupancy and pointers and overflow, and ignore same-cycle in_valid and out_ready.

Reset
REQ-030 SHALL, while reset is 0, force state EMPTY, pointers 0, occupancy 0, overflow 0, out_valid 0, out_seq 0, out_pc/out_inst/out_cause 0, out_trap 0.
REQ-031 SHALL, when reset asserts mid-stream, discard all entries immediately without waiting for a clock edge.
REQ-032 SHALL drive in_ready 1 in the first cycle after reset release.

Configuration
REQ-033 SHALL use macro COMMIT_TRACE_SEQNUM_EN.
REQ-034 SHALL, with COMMIT_TRACE_SEQNUM_EN defined, stamp each enqueued entry with a 16-bit counter incremented per accepted commit (wraps 0xFFFF->0x0000, reset and flush to 0, dropped commits not counted).
REQ-035 SHALL, without COMMIT_TRACE_SEQNUM_EN, tie out_seq to 0 and store no sequence field.

Verification
REQ-036 SHALL cover: NRET=2, in_valid=2'b11, pc 0x100/0x104, out_ready=1 -> out_pc 0x100 then 0x104 on consecutive cycles, out_seq 0 then 1.
REQ-037 SHALL cover: in_valid=2'b10, channel 1 pc 0x200 -> single entry with out_pc 0x200, out_trap 0.
REQ-038 SHALL cover: DEPTH=8, out_ready=0, four cycles of 2'b11 -> occupancy 8, in_ready 0; fifth 2'b11 -> overflow 1, occupancy stays 8.
REQ-039 SHALL cover: OVF with 8 entries, out_ready=1 -> 8 entries drained in order, out_valid 0 after, in_ready 0 until flush.
REQ-040 SHALL cover: trap commit cause 0x2, out_ready stalled 3 cycles -> out_trap 1, out_cause 0x2 held stable all 3 cycles.
REQ-041 SHALL cover: reset driven 0 asynchronously with 5 entries queued -> out_valid 0 before next clock edge, out_seq 0 after release.
